// File: rtl/axis_pkt_arbiter.sv
// axis_pkt_arbiter
//   Packet-level round-robin arbiter that shares one AXI-Stream write port
//   between NumSrc producers. A grant is held from the first beat of a packet
//   until its last beat, so packets never interleave downstream. The output
//   goes through a one-entry register slice, and m_src tags every beat with
//   the source that produced it.
//
// Optional feature (compile-time macro AXIS_ARB_MAXLEN_EN):
//   When defined, a packet reaching MaxBeats accepted beats without s_last is
//   cut: that beat leaves with m_last=1, err_trunc pulses for one cycle while
//   the beat is on m_*, and the rest of the source's packet is arbitrated as a
//   new packet. When undefined, there is no length limit and err_trunc is 0.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   s_data     flattened source data, source i at [i*DataWidth +: DataWidth]
//   s_valid    per-source valid
//   s_last     per-source end-of-packet
//   s_ready    per-source ready (only the granted source can see a 1)
//   m_data     output beat data
//   m_valid    output beat valid
//   m_last     output end-of-packet
//   m_ready    downstream ready
//   m_src      source ID of the beat on m_data
//   pkt_count  packets forwarded, wraps at 2^32
//   err_trunc  one-cycle truncation pulse
//
// state | meaning
// IDLE  | no grant; all s_ready low; picks the next requester round-robin
// BUSY  | source gnt owns the port until its last (or truncated) beat
module axis_pkt_arbiter #(
  parameter int  DataWidth = 32,
  parameter int  NumSrc    = 4,
  parameter int  MaxBeats  = 256,
  localparam int SrcW      = $clog2(NumSrc)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NumSrc*DataWidth-1:0] s_data,
  input  logic [NumSrc-1:0]           s_valid,
  input  logic [NumSrc-1:0]           s_last,
  output logic [NumSrc-1:0]           s_ready,
  output logic [DataWidth-1:0]        m_data,
  output logic                        m_valid,
  output logic                        m_last,
  input  logic                        m_ready,
  output logic [SrcW-1:0]             m_src,
  output logic [31:0]                 pkt_count,
  output logic                        err_trunc
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} arbState_t;

  arbState_t             state;
  arbState_t             stateNext;
  logic [SrcW-1:0]       gnt;
  logic [SrcW-1:0]       rrPtr;
  logic [SrcW-1:0]       pick;
  logic [SrcW-1:0]       gntInc;
  logic [DataWidth-1:0]  selData;
  logic                  selValid;
  logic                  selLast;
  logic                  slotFree;
  logic                  accept;
  logic                  pktEnd;
  logic                  startGrant;
  logic                  truncHit;

  assign slotFree = !m_valid || m_ready;
  assign selValid = s_valid[gnt];
  assign selLast  = s_last[gnt];
  assign gntInc   = (gnt == SrcW'(NumSrc - 1)) ? '0 : gnt + 1'b1;

  // Walk offsets from the highest down so the smallest offset from rrPtr
  // with a set valid is the assignment that sticks.
  always_comb begin
    pick = rrPtr;
    for (int i = NumSrc - 1; i >= 0; i--) begin
      int idx;
      idx = (int'(rrPtr) + i) % NumSrc;
      if (s_valid[SrcW'(idx)]) pick = SrcW'(idx);
    end
  end

  always_comb begin
    selData = '0;
    for (int i = 0; i < NumSrc; i++) begin
      if (gnt == SrcW'(i)) selData = s_data[i*DataWidth +: DataWidth];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext  = state;
    s_ready    = '0;
    accept     = 1'b0;
    pktEnd     = 1'b0;
    startGrant = 1'b0;
    case (state)
      IDLE: begin
        if (|s_valid) begin
          stateNext  = BUSY;
          startGrant = 1'b1;
        end
      end
      BUSY: begin
        s_ready[gnt] = slotFree;
        accept       = selValid && slotFree;
        pktEnd       = accept && (selLast || truncHit);
        if (pktEnd) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gnt       <= '0;
      rrPtr     <= '0;
      m_data    <= '0;
      m_valid   <= 1'b0;
      m_last    <= 1'b0;
      m_src     <= '0;
      pkt_count <= '0;
    end else begin
      if (startGrant) gnt <= pick;
      if (accept) begin
        m_data  <= selData;
        m_last  <= selLast || truncHit;
        m_src   <= gnt;
        m_valid <= 1'b1;
      end else if (m_ready) begin
        m_valid <= 1'b0;
      end
      if (pktEnd) begin
        rrPtr     <= gntInc;
        pkt_count <= pkt_count + 32'd1;
      end
    end
  end

`ifdef AXIS_ARB_MAXLEN_EN
  localparam int BeatW = $clog2(MaxBeats + 1);

  logic [BeatW-1:0] beatCnt;

  // beatCnt holds beats already accepted, so this beat is number MaxBeats.
  assign truncHit = !selLast && (beatCnt == BeatW'(MaxBeats - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      beatCnt   <= '0;
      err_trunc <= 1'b0;
    end else begin
      if (startGrant)  beatCnt <= '0;
      else if (accept) beatCnt <= beatCnt + 1'b1;
      err_trunc <= accept && truncHit;
    end
  end
`else
  assign truncHit  = 1'b0;
  assign err_trunc = 1'b0;
`endif

endmodule

// File: tb/tb_axis_pkt_arbiter.sv
module tb_axis_pkt_arbiter;
  localparam int DW = 32;
  localparam int NS = 4;
  localparam int MB = 8;
  localparam int SW = 2;
`ifdef AXIS_ARB_MAXLEN_EN
  localparam bit MaxLenEn = 1'b1;
`else
  localparam bit MaxLenEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic [NS*DW-1:0] s_data;
  logic [NS-1:0] s_valid, s_last, s_ready;
  logic [DW-1:0] m_data;
  logic m_valid, m_last, m_ready;
  logic [SW-1:0] m_src;
  logic [31:0] pkt_count;
  logic err_trunc;

  axis_pkt_arbiter #(.DataWidth(DW), .NumSrc(NS), .MaxBeats(MB)) dut (
    .clk(clk), .reset(reset), .s_data(s_data), .s_valid(s_valid),
    .s_last(s_last), .s_ready(s_ready), .m_data(m_data), .m_valid(m_valid),
    .m_last(m_last), .m_ready(m_ready), .m_src(m_src),
    .pkt_count(pkt_count), .err_trunc(err_trunc));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [DW-1:0] data;
    bit            last;
    bit            trunc;
  } beat_t;

  // Per-source input beats and the beats the port should emit for them.
  beat_t srcQ[NS][$];
  beat_t expQ[NS][$];
  int chunk[NS];
  int expPkts;
  int startIt[NS], gapAfter[NS], gapLen[NS];
  bit readyPat[$];
  int stallPct, gapPct;
  int pktSrcLog[$], pktStartIt[$], pktEndIt[$];
  logic [31:0] pcLog[$];

  task automatic clear_cfg();
    for (int i = 0; i < NS; i++) begin
      startIt[i] = 0; gapAfter[i] = -1; gapLen[i] = 0;
      srcQ[i].delete(); expQ[i].delete();
    end
    readyPat.delete();
    stallPct = 0; gapPct = 0; expPkts = 0;
  endtask

  task automatic add_pkt(input int src, input int len, input bit seq);
    beat_t b;
    for (int k = 0; k < len; k++) begin
      b.data  = seq ? DW'(k) : $urandom;
      b.last  = (k == len - 1);
      b.trunc = 1'b0;
      srcQ[src].push_back(b);
      chunk[src]++;
      if (MaxLenEn && !b.last && chunk[src] == MB) begin
        b.last = 1'b1; b.trunc = 1'b1;
      end
      if (b.last) begin chunk[src] = 0; expPkts++; end
      expQ[src].push_back(b);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; s_valid = '0; s_last = '0; m_ready = 1'b0;
    for (int i = 0; i < NS; i++) chunk[i] = 0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic run_traffic(input int budget);
    int it; bit done; bit allEmpty; bit consumed[NS]; int sent[NS];
    int gapRem[NS]; bit gapDone[NS];
    bit prevValid, prevXfer, curOpen, newBeat, expTr, v;
    logic [DW-1:0] prevData; logic prevLast; logic [SW-1:0] prevSrc, curSrc;
    logic [31:0] pc0; beat_t h; int s; int runPkts;
    for (int i = 0; i < NS; i++) begin
      consumed[i] = 0; sent[i] = 0; gapRem[i] = 0; gapDone[i] = 0;
    end
    prevValid = 0; prevXfer = 0; curOpen = 0; curSrc = '0;
    prevData = '0; prevLast = 0; prevSrc = '0;
    pktSrcLog.delete(); pktStartIt.delete(); pktEndIt.delete(); pcLog.delete();
    runPkts = expPkts; expPkts = 0;
    pc0 = pkt_count;
    @(posedge clk);
    it = 0; done = 0;
    while (!done && it < budget) begin
      #1;
      for (int i = 0; i < NS; i++) begin
        if (consumed[i]) begin h = srcQ[i].pop_front(); sent[i]++; consumed[i] = 0; end
        v = (srcQ[i].size() > 0) && (it >= startIt[i]);
        if (v && gapAfter[i] >= 0 && !gapDone[i] && sent[i] == gapAfter[i]) begin
          gapRem[i] = gapLen[i]; gapDone[i] = 1;
        end
        if (gapRem[i] > 0) begin v = 0; gapRem[i]--; end
        else if (v && gapPct > 0 && $urandom_range(99) < gapPct) v = 0;
        s_valid[i] = v;
        if (srcQ[i].size() > 0) begin
          s_data[i*DW +: DW] = srcQ[i][0].data; s_last[i] = srcQ[i][0].last;
        end else begin
          s_data[i*DW +: DW] = $urandom; s_last[i] = 1'($urandom);
        end
      end
      if (readyPat.size() > 0) m_ready = readyPat.pop_front();
      else m_ready = ($urandom_range(99) >= stallPct);
      @(negedge clk);
      pcLog.push_back(pkt_count);
      checks++;
      if ($countones(s_ready) > 1) begin
        errors++; $display("FAIL one_ready: s_ready=%b, at most one bit allowed", s_ready);
      end
      for (int i = 0; i < NS; i++) consumed[i] = s_valid[i] && s_ready[i];
      if (prevValid && !prevXfer) begin
        checks++;
        if (!m_valid || m_data !== prevData || m_last !== prevLast || m_src !== prevSrc) begin
          errors++;
          $display("FAIL stall_hold: got v=%b d=%h l=%b s=%0d, held beat d=%h l=%b s=%0d",
                   m_valid, m_data, m_last, m_src, prevData, prevLast, prevSrc);
        end
      end
      newBeat = m_valid && (!prevValid || prevXfer);
      expTr = 0;
      if (newBeat && expQ[m_src].size() > 0) expTr = expQ[m_src][0].trunc;
      checks++;
      if (err_trunc !== expTr) begin
        errors++; $display("FAIL err_trunc: got %b expected %b at cycle %0d", err_trunc, expTr, it);
      end
      if (m_valid && m_ready) begin
        s = int'(m_src);
        checks++;
        if (expQ[s].size() == 0) begin
          errors++; $display("FAIL extra_beat: src %0d data %h, no beat expected", s, m_data);
        end else begin
          h = expQ[s].pop_front();
          if (m_data !== h.data || m_last !== h.last || (curOpen && m_src !== curSrc)) begin
            errors++;
            $display("FAIL out_beat: src %0d got d=%h l=%b, expected d=%h l=%b (open pkt src %0d=%b)",
                     s, m_data, m_last, h.data, h.last, curSrc, curOpen);
          end
          if (!curOpen) begin pktSrcLog.push_back(s); pktStartIt.push_back(it); end
          curOpen = !h.last; curSrc = m_src;
          if (h.last) pktEndIt.push_back(it);
        end
      end
      prevValid = m_valid; prevXfer = m_valid && m_ready;
      prevData = m_data; prevLast = m_last; prevSrc = m_src;
      allEmpty = 1;
      for (int i = 0; i < NS; i++) if (expQ[i].size() > 0) allEmpty = 0;
      done = allEmpty;
      @(posedge clk);
      it++;
    end
    #1;
    s_valid = '0; m_ready = 1'b1;
    checks++;
    if (!done) begin
      errors++; $display("FAIL timeout: traffic not drained within %0d cycles", budget);
    end
    @(negedge clk);
    checks++;
    if (pkt_count !== pc0 + 32'(runPkts)) begin
      errors++; $display("FAIL pkt_count: got %0d expected %0d", pkt_count, pc0 + 32'(runPkts));
    end
    for (int i = 0; i < NS; i++) begin srcQ[i].delete(); expQ[i].delete(); end
  endtask

  task automatic check_outputs_zero(input string tag);
    checks++;
    if (m_valid !== 1'b0 || m_last !== 1'b0 || m_data !== '0 || m_src !== '0 ||
        pkt_count !== '0 || err_trunc !== 1'b0 || s_ready !== '0) begin
      errors++;
      $display("FAIL %s: v=%b l=%b d=%h s=%0d pc=%0d et=%b rdy=%b, all must be 0",
               tag, m_valid, m_last, m_data, m_src, pkt_count, err_trunc, s_ready);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; s_valid = '0; s_last = '0; s_data = '0; m_ready = 1'b0;
    for (int i = 0; i < NS; i++) chunk[i] = 0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset_state");
    reset = 1'b1;
  endtask

  task automatic test_single_packet();
    clear_cfg();
    add_pkt(0, 16, 1'b1);
    run_traffic(100);
    checks++;
    if (pktSrcLog.size() < 1 || pktSrcLog[0] != 0 || pktStartIt[0] != 2 ||
        pktEndIt[pktEndIt.size()-1] != (MaxLenEn ? 18 : 17)) begin
      errors++;
      $display("FAIL single_timing: pkts=%0d first_src=%0d start=%0d end=%0d, expected src 0 start 2 end %0d",
               pktSrcLog.size(), pktSrcLog.size() > 0 ? pktSrcLog[0] : -1,
               pktStartIt.size() > 0 ? pktStartIt[0] : -1,
               pktEndIt.size() > 0 ? pktEndIt[pktEndIt.size()-1] : -1, MaxLenEn ? 18 : 17);
    end
    checks++;
    if (pkt_count !== (MaxLenEn ? 32'd2 : 32'd1)) begin
      errors++; $display("FAIL single_pkt_count: got %0d", pkt_count);
    end
  endtask

  task automatic test_fairness();
    int order[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    do_reset();
    clear_cfg();
    for (int r = 0; r < 2; r++) for (int i = 0; i < NS; i++) add_pkt(i, 4, 1'b0);
    run_traffic(200);
    checks++;
    if (pktSrcLog.size() != 8) begin
      errors++; $display("FAIL fair_count: got %0d packets expected 8", pktSrcLog.size());
    end else begin
      for (int k = 0; k < 8; k++) begin
        checks++;
        if (pktSrcLog[k] != order[k] || (k > 0 && pktStartIt[k] != pktEndIt[k-1] + 2)) begin
          errors++;
          $display("FAIL fair_order: pkt %0d src %0d start %0d, expected src %0d start %0d",
                   k, pktSrcLog[k], pktStartIt[k], order[k], k > 0 ? pktEndIt[k-1] + 2 : 2);
        end
      end
    end
    checks++;
    if (pcLog.size() <= 30 || pcLog[29] !== 32'd5 || pcLog[30] !== 32'd6) begin
      errors++;
      $display("FAIL fair_pkt_count: at cycle 29/30 got %0d/%0d expected 5/6",
               pcLog.size() > 29 ? pcLog[29] : 32'hFFFF_FFFF, pcLog.size() > 30 ? pcLog[30] : 32'hFFFF_FFFF);
    end
  endtask

  task automatic test_backpressure();
    clear_cfg();
    for (int r = 0; r < 16; r++) begin
      readyPat.push_back(1); readyPat.push_back(0); readyPat.push_back(0); readyPat.push_back(1);
    end
    add_pkt(1, 16, 1'b0);
    run_traffic(200);
    checks++;
    if (pktSrcLog.size() != (MaxLenEn ? 2 : 1) || pktSrcLog[0] != 1) begin
      errors++; $display("FAIL bp_packets: got %0d packets, first src %0d",
                         pktSrcLog.size(), pktSrcLog.size() > 0 ? pktSrcLog[0] : -1);
    end
  endtask

  task automatic test_source_gap();
    clear_cfg();
    add_pkt(2, 8, 1'b0);
    add_pkt(1, 6, 1'b0);
    gapAfter[2] = 4; gapLen[2] = 5; startIt[1] = 3;
    run_traffic(200);
    checks++;
    if (pktSrcLog.size() != 2 || pktSrcLog[0] != 2 || pktSrcLog[1] != 1 ||
        pktEndIt[0] - pktStartIt[0] != 12 || pktStartIt[1] <= pktEndIt[0]) begin
      errors++;
      $display("FAIL gap_hold: pkts=%0d srcs=%0d,%0d span=%0d, expected srcs 2,1 span 12",
               pktSrcLog.size(), pktSrcLog.size() > 0 ? pktSrcLog[0] : -1,
               pktSrcLog.size() > 1 ? pktSrcLog[1] : -1,
               pktEndIt.size() > 0 ? pktEndIt[0] - pktStartIt[0] : -1);
    end
  endtask

  task automatic test_reset_mid();
    int k; bit hit;
    k = 0; hit = 0;
    m_ready = 1'b1;
    for (int c = 0; c < 40 && !hit; c++) begin
      @(posedge clk); #1;
      s_valid = 4'b1000; s_data[3*DW +: DW] = 32'h100 + 32'(k); s_last[3] = (k == 15);
      @(negedge clk);
      if (m_valid && m_data == 32'h107) hit = 1;
      else if (s_valid[3] && s_ready[3]) k++;
    end
    checks++;
    if (!hit) begin errors++; $display("FAIL mid_reach: beat 7 of src 3 never appeared"); end
    reset = 1'b0;
    #1;
    check_outputs_zero("mid_reset");
    @(posedge clk); #1;
    check_outputs_zero("mid_reset_held");
    @(negedge clk);
    s_valid = '0; reset = 1'b1;
    for (int i = 0; i < NS; i++) chunk[i] = 0;
    clear_cfg();
    add_pkt(3, 3, 1'b0);
    add_pkt(0, 3, 1'b0);
    run_traffic(100);
    checks++;
    if (pktSrcLog.size() != 2 || pktSrcLog[0] != 0 || pktSrcLog[1] != 3) begin
      errors++; $display("FAIL mid_rr_ptr: first src %0d, expected 0 then 3",
                         pktSrcLog.size() > 0 ? pktSrcLog[0] : -1);
    end
  endtask

  task automatic test_maxlen();
    clear_cfg();
    add_pkt(2, 12, 1'b1);
    run_traffic(100);
    checks++;
    if (pktSrcLog.size() != (MaxLenEn ? 2 : 1) ||
        pktEndIt[0] - pktStartIt[0] != (MaxLenEn ? 7 : 11)) begin
      errors++;
      $display("FAIL maxlen_split: got %0d packets first len %0d, expected %0d packets first len %0d",
               pktSrcLog.size(), pktEndIt.size() > 0 ? pktEndIt[0] - pktStartIt[0] + 1 : -1,
               MaxLenEn ? 2 : 1, MaxLenEn ? 8 : 12);
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 3; r++) begin
      clear_cfg();
      gapPct = 20; stallPct = 30;
      for (int i = 0; i < NS; i++) begin
        startIt[i] = $urandom_range(10);
        for (int p = 0; p < int'($urandom_range(3, 1)); p++) add_pkt(i, $urandom_range(20, 1), 1'b0);
      end
      run_traffic(2000);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_packet();
    test_fairness();
    test_backpressure();
    test_source_gap();
    test_reset_mid();
    test_maxlen();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
